// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle core: FSM states, opcode classes and
// the datapath mux/ALU encodings used by both control and datapath.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXECR, S_EXECI, S_ALUWB, S_MEMADR,
    S_MEMREAD, S_MEMWB, S_MEMWRITE, S_CMP, S_BRANCH, S_FAULT
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALUR, CLS_ALUI, CLS_MEM, CLS_CMP, CLS_BRANCH, CLS_UNDEF
  } op_class_e;

  localparam logic [3:0] OP_ALUR_LAST = 4'b0110;
  localparam logic [3:0] OP_ALUI_LAST = 4'b1000;
  localparam logic [3:0] OP_LOAD      = 4'b1001;
  localparam logic [3:0] OP_STORE     = 4'b1010;
  localparam logic [3:0] OP_CMPI      = 4'b1011;
  localparam logic [3:0] OP_BR        = 4'b1100;
  localparam logic [3:0] OP_BRZ       = 4'b1101;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_ONE = 2'b10;

  localparam logic [1:0] IMM_ALU  = 2'b00;
  localparam logic [1:0] IMM_MEM  = 2'b01;
  localparam logic [1:0] IMM_NONE = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  function automatic op_class_e op_class(input logic [3:0] op);
    if (op <= OP_ALUR_LAST)                 return CLS_ALUR;
    else if (op <= OP_ALUI_LAST)            return CLS_ALUI;
    else if (op == OP_LOAD || op == OP_STORE) return CLS_MEM;
    else if (op == OP_CMPI)                 return CLS_CMP;
    else if (op == OP_BR || op == OP_BRZ)   return CLS_BRANCH;
    else                                    return CLS_UNDEF;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch resolution: unconditional branches always take, branch-if-zero
// takes only when the Z flag is set.
import multicycle_pkg::*;

module branch_cond (
  input  logic [3:0] op,
  input  logic       zero,
  output logic       taken
);

  always_comb begin
    taken = (op == OP_BR) || ((op == OP_BRZ) && zero);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/write-back
// over a shared ALU and one memory port, trapping undefined opcodes.
import multicycle_pkg::*;

module multicycle_control #(
  parameter int RESET_FAULT_CLR = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       flags_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       fault
);

  localparam logic CLR_ON_RESET = (RESET_FAULT_CLR != 0);

  state_e state_q, state_d;
  logic   fault_q, fault_d;
  logic   br_taken;

  branch_cond u_branch_cond (
    .op    (op),
    .zero  (zero),
    .taken (br_taken)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      fault_q <= CLR_ON_RESET ? 1'b0 : fault_q;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    flags_write = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    imm_src     = IMM_NONE;
    alu_op      = ALU_ADD;
    result_src  = RES_ALUOUT;

    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_ONE;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target (old PC + imm) is computed here while the class is decoded.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_ALU;
        case (op_class(op))
          CLS_ALUR:   state_d = S_EXECR;
          CLS_ALUI:   state_d = S_EXECI;
          CLS_MEM:    state_d = S_MEMADR;
          CLS_CMP:    state_d = S_CMP;
          CLS_BRANCH: state_d = S_BRANCH;
          default:    state_d = S_FAULT;
        endcase
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_FUNC;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_ALU;
        alu_op    = ALU_FUNC;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write   = 1'b1;
        flags_write = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_MEM;
        state_d   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = RES_MEMDATA;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_CMP: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        imm_src     = IMM_ALU;
        alu_op      = ALU_SUB;
        flags_write = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        pc_write = br_taken;
        state_d  = S_FETCH;
      end
      S_FAULT: begin
        imm_src = 2'b00;
        state_d = S_FAULT;
      end
      default: state_d = S_FETCH;
    endcase

    fault_d = fault_q | (state_d == S_FAULT);

    // Reset wins in every state: the bus request drops and any access is abandoned.
    if (reset) begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      flags_write = 1'b0;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      imm_src     = 2'b00;
      alu_op      = 2'b00;
      result_src  = 2'b00;
    end
  end

  assign fault = fault_q & ~(reset & CLR_ON_RESET);

endmodule
